vram_render_arbiter: RTL and testbench

Read-side responder for the renderer VRAM bus. It accepts word-read requests from the three renderer bus masters (layer 0, layer 1, sprite) and arbitrates them round-robin onto the single read port of the 32-bit VRAM. It returns each word with a one-cycle acknowledge pulse. It sits between the renderers and the VRAM macro, below the CPU access path, which can claim the port cycle by cycle.

---
 rtl/vram_render_arbiter_pkg.sv | 19 +
 rtl/vram_render_arbiter_rr_pick.sv | 30 +++
 rtl/vram_render_arbiter.sv | 110 +++++++++++
 tb/tb_vram_render_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vram_render_arbiter_pkg.sv
// Shared constants and types for the renderer-side VRAM read arbiter.
package vram_render_arbiter_pkg;

  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 32;

  localparam int M_L0  = 0;
  localparam int M_L1  = 1;
  localparam int M_SPR = 2;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // IDLE: nothing in flight; RESP: the RAM is returning a word this cycle.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/vram_render_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or above ptr wins.
module vram_render_arbiter_rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  int idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      for (int j = 0; j < N; j++) begin
        if (!valid && (j == idx) && req[j]) begin
          grant[j] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vram_render_arbiter.sv
// Round-robin read arbiter from the renderer masters onto the single VRAM read port.
module vram_render_arbiter
  import vram_render_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = VRAM_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]        m_strobe,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [VRAM_DATA_W-1:0]        m_rddata,
  input  logic                          cpu_hold,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_rden,
  input  logic [VRAM_DATA_W-1:0]        ram_rddata,
  output logic [15:0]                   grant_stall_cnt,
  input  logic                          stat_clr
);

  localparam int ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  pipe_state_e             state_q;
  logic [ID_W-1:0]         inflight_id;
  logic [ID_W-1:0]         rr_ptr;
  logic [ADDR_W-1:0]       addr_q;
  logic [15:0]             stall_q;

  logic                    inflight_valid;
  logic [NUM_MASTERS-1:0]  inflight_onehot;
  logic [NUM_MASTERS-1:0]  eligible;
  logic [NUM_MASTERS-1:0]  pick_grant;
  logic                    pick_valid;
  logic                    grant_en;
  logic [ID_W-1:0]         winner;
  logic [ID_W-1:0]         next_ptr;
  logic [ADDR_W-1:0]       win_addr;

  assign inflight_valid = (state_q == ST_RESP);

  always_comb begin
    inflight_onehot = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      inflight_onehot[j] = inflight_valid && (int'(inflight_id) == j);
    end
  end

  // The master being acked is masked even if it ignores the strobe protocol.
  assign eligible = m_strobe & ~inflight_onehot;

  vram_render_arbiter_rr_pick #(
    .N     (NUM_MASTERS),
    .PTR_W (ID_W)
  ) u_rr_pick (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign grant_en = pick_valid && !cpu_hold;

  always_comb begin
    winner   = '0;
    win_addr = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (pick_grant[j]) begin
        winner   = ID_W'(j);
        win_addr = m_addr[j*ADDR_W +: ADDR_W];
      end
    end
  end

  assign next_ptr = (int'(winner) == NUM_MASTERS - 1) ? '0 : winner + ID_W'(1);

  assign ram_rden        = grant_en;
  assign ram_addr        = grant_en ? win_addr : addr_q;
  assign m_ack           = inflight_onehot;
  assign m_rddata        = ram_rddata;
  assign grant_stall_cnt = stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      inflight_id <= '0;
      rr_ptr      <= ID_W'(M_L0);
      addr_q      <= '0;
    end else begin
      state_q <= grant_en ? ST_RESP : ST_IDLE;
      if (grant_en) begin
        inflight_id <= winner;
        rr_ptr      <= next_ptr;
        addr_q      <= win_addr;
      end
    end
  end

  // Stall = someone is waiting but nothing was granted (CPU hold or only the inflight master asking).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (stat_clr) begin
      stall_q <= '0;
    end else if ((|m_strobe) && !grant_en && (stall_q != STALL_MAX)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_vram_render_arbiter.sv
// Directed bench for vram_render_arbiter with a behavioural VRAM and strobe-dropping masters.
`timescale 1ns/1ps
module tb_vram_render_arbiter;
  import vram_render_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 15;

  localparam logic [AW-1:0] A0 = 15'h0010;
  localparam logic [AW-1:0] A1 = 15'h0020;
  localparam logic [AW-1:0] A2 = 15'h1234;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*AW-1:0] m_addr;
  logic [N-1:0]    m_strobe;
  logic [N-1:0]    m_ack;
  logic [31:0]     m_rddata;
  logic            cpu_hold = 1'b0;
  logic [AW-1:0]   ram_addr;
  logic            ram_rden;
  logic [31:0]     ram_rddata = 32'h0;
  logic [15:0]     grant_stall_cnt;
  logic            stat_clr = 1'b0;

  logic [N-1:0]    want = '0;
  logic [N-1:0]    viol_mask = '0;

  int checks   = 0;
  int failures = 0;

  // Clock / reset
  always #5 clk = ~clk;

  assign m_addr   = {A2, A1, A0};
  // Masters drop their strobe during their own ack unless told to misbehave.
  assign m_strobe = want & ~(m_ack & ~viol_mask);

  // Behavioural VRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (ram_rden) begin
      ram_rddata <= (ram_addr == 15'h1234) ? 32'hDEADBEEF : (32'hC0DE0000 | {17'b0, ram_addr});
    end
  end

  vram_render_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_W      (AW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .m_addr          (m_addr),
    .m_strobe        (m_strobe),
    .m_ack           (m_ack),
    .m_rddata        (m_rddata),
    .cpu_hold        (cpu_hold),
    .ram_addr        (ram_addr),
    .ram_rden        (ram_rden),
    .ram_rddata      (ram_rddata),
    .grant_stall_cnt (grant_stall_cnt),
    .stat_clr        (stat_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move to the next cycle's drive point (just after the falling edge).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Sample point: one time unit before the rising edge.
  task automatic settle();
    #4;
  endtask

  logic [AW-1:0] exp_addr [4] = '{A0, A1, A2, A0};
  logic [N-1:0]  exp_ack  [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
  logic [31:0]   exp_data [4] = '{32'h0, 32'hC0DE0010, 32'hC0DE0020, 32'hDEADBEEF};

  initial begin
    #1_500_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Reset state
    next_cycle();
    settle();
    check("rst_ack", 32'(m_ack), 32'h0);
    check("rst_rden", 32'(ram_rden), 32'h0);
    check("rst_addr", 32'(ram_addr), 32'h0);
    check("rst_stall", 32'(grant_stall_cnt), 32'h0);
    check("rst_rddata", m_rddata, 32'h0);
    next_cycle();
    rst_n = 1'b1;

    // Single request from the sprite master
    next_cycle();
    want = 3'b100;
    settle();
    check("single_rden", 32'(ram_rden), 32'h1);
    check("single_addr", 32'(ram_addr), 32'h1234);
    check("single_noack", 32'(m_ack), 32'h0);
    next_cycle();
    want = 3'b000;
    settle();
    check("single_ack", 32'(m_ack), 32'b100);
    check("single_data", m_rddata, 32'hDEADBEEF);
    check("single_idle_rden", 32'(ram_rden), 32'h0);
    check("single_hold_addr", 32'(ram_addr), 32'h1234);
    next_cycle();
    settle();
    check("single_ack_clear", 32'(m_ack), 32'h0);

    // All three requesting: grants 0,1,2,0 with acks trailing by one
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      want = 3'b111;
      settle();
      check($sformatf("rr_rden_%0d", c), 32'(ram_rden), 32'h1);
      check($sformatf("rr_addr_%0d", c), 32'(ram_addr), 32'(exp_addr[c]));
      check($sformatf("rr_ack_%0d", c), 32'(m_ack), 32'(exp_ack[c]));
      if (c > 0) check($sformatf("rr_data_%0d", c), m_rddata, exp_data[c]);
    end
    next_cycle();
    want = 3'b000;
    settle();
    check("rr_last_ack", 32'(m_ack), 32'b001);
    check("rr_last_data", m_rddata, 32'hC0DE0010);
    check("rr_last_rden", 32'(ram_rden), 32'h0);

    // CPU hold for three cycles with master 1 pending
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      want = 3'b010;
      cpu_hold = 1'b1;
      settle();
      check($sformatf("hold_rden_%0d", c), 32'(ram_rden), 32'h0);
      check($sformatf("hold_ack_%0d", c), 32'(m_ack), 32'h0);
    end
    next_cycle();
    cpu_hold = 1'b0;
    settle();
    check("hold_release_rden", 32'(ram_rden), 32'h1);
    check("hold_release_addr", 32'(ram_addr), 32'h0020);
    check("hold_stall_cnt", 32'(grant_stall_cnt), 32'd3);
    next_cycle();
    want = 3'b000;
    settle();
    check("hold_ack", 32'(m_ack), 32'b010);
    check("hold_data", m_rddata, 32'hC0DE0020);

    // Master 0 keeps strobing through its ack
    next_cycle();
    viol_mask = 3'b001;
    want = 3'b001;
    settle();
    check("viol_grant_rden", 32'(ram_rden), 32'h1);
    check("viol_grant_addr", 32'(ram_addr), 32'h0010);
    next_cycle();
    settle();
    check("viol_ack", 32'(m_ack), 32'b001);
    check("viol_no_regrant", 32'(ram_rden), 32'h0);
    next_cycle();
    settle();
    check("viol_regrant", 32'(ram_rden), 32'h1);
    check("viol_regrant_ack", 32'(m_ack), 32'h0);
    next_cycle();
    want = 3'b000;
    viol_mask = 3'b000;
    settle();
    check("viol_ack2", 32'(m_ack), 32'b001);
    check("viol_stall", 32'(grant_stall_cnt), 32'd4);

    // Reset during the response cycle
    next_cycle();
    want = 3'b010;
    settle();
    check("rstmid_grant", 32'(ram_rden), 32'h1);
    next_cycle();
    want = 3'b000;
    rst_n = 1'b0;
    settle();
    check("rstmid_ack_dropped", 32'(m_ack), 32'h0);
    check("rstmid_stall", 32'(grant_stall_cnt), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    want = 3'b110;
    settle();
    check("rstmid_first_rden", 32'(ram_rden), 32'h1);
    check("rstmid_first_addr", 32'(ram_addr), 32'h0020);
    next_cycle();
    want = 3'b000;
    settle();
    check("rstmid_first_ack", 32'(m_ack), 32'b010);

    // Stall counter saturation and clear priority
    next_cycle();
    want = 3'b001;
    cpu_hold = 1'b1;
    repeat (65534) next_cycle();
    settle();
    check("sat_fffe", 32'(grant_stall_cnt), 32'hFFFE);
    check("sat_no_rden", 32'(ram_rden), 32'h0);
    repeat (2) next_cycle();
    settle();
    check("sat_ffff", 32'(grant_stall_cnt), 32'hFFFF);
    next_cycle();
    settle();
    check("sat_hold", 32'(grant_stall_cnt), 32'hFFFF);
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    settle();
    check("clr_wins", 32'(grant_stall_cnt), 32'h0);
    next_cycle();
    settle();
    check("clr_restart", 32'(grant_stall_cnt), 32'h1);
    next_cycle();
    want = 3'b000;
    cpu_hold = 1'b0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
